// File: rtl/instruction_loader.sv
// instruction_loader: byte-stream writer for the instruction memory.
// Receives a 24-bit big-endian word count followed by big-endian 32-bit
// words over a valid/ready handshake and issues one-cycle write strobes.
// Optional build macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// that must match every byte accepted since start.
// ADDR_WIDTH is expected to lie in 16..24 (length bytes are packed into it).
module instruction_loader #(
  parameter int SIZE         = 110,
  parameter int ADDR_WIDTH   = 20,
  parameter int BASE_ADDRESS = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_address,
  output logic [31:0]           wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] word_count
);

  localparam logic [23:0]           SIZE_L = 24'(SIZE);
  localparam logic [ADDR_WIDTH-1:0] BASE_L = ADDR_WIDTH'(BASE_ADDRESS);
  localparam logic [ADDR_WIDTH-1:0] ONE_L  = ADDR_WIDTH'(1);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5,
    S_CHK   = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;
`endif

  state_t                state_q, state_d;
  logic                  armed_q;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [1:0]            idx_q, idx_d;
  logic [23:0]           asm_q, asm_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [ADDR_WIDTH-1:0] wr_address_q, wr_address_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic                  byte_ready_q, byte_ready_d;
  logic                  wr_en_q, wr_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  logic        accept;
  logic [23:0] len_full;
  state_t      finish_state;

  assign accept   = byte_valid && byte_ready_q;
  assign len_full = {len_q[15:0], byte_data};

  // Where a completed load goes: straight to DONE, or via the checksum byte.
`ifdef LOADER_CHECKSUM_EN
  assign finish_state = S_CHK;
`else
  assign finish_state = S_DONE;
`endif

  // State register; start is only honoured once a clock edge has passed since reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      len_q        <= '0;
      idx_q        <= '0;
      asm_q        <= '0;
      count_q      <= '0;
      wr_address_q <= '0;
      wr_data_q    <= '0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      len_q        <= len_d;
      idx_q        <= idx_d;
      asm_q        <= asm_d;
      count_q      <= count_d;
      wr_address_q <= wr_address_d;
      wr_data_q    <= wr_data_d;
      byte_ready_q <= byte_ready_d;
      wr_en_q      <= wr_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  // Next-state logic; outputs are decoded from the next state so they register cleanly.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    asm_d        = asm_q;
    count_d      = count_q;
    wr_address_d = wr_address_q;
    wr_data_d    = wr_data_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d       = csum_q;
    if (accept) begin
      csum_d = csum_q ^ byte_data;
    end
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start && armed_q) begin
          state_d = S_LEN;
          len_d   = '0;
          idx_d   = '0;
          asm_d   = '0;
          count_d = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end

      S_LEN: begin
        if (accept) begin
          len_d = len_full[ADDR_WIDTH-1:0];
          if (idx_q == 2'd2) begin
            idx_d = '0;
            if (len_full == 24'd0) begin
              state_d = finish_state;
            end else if (len_full > SIZE_L) begin
              state_d = S_ERROR;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          if (idx_q == 2'd3) begin
            idx_d        = '0;
            wr_data_d    = {asm_q, byte_data};
            wr_address_d = BASE_L + count_q;
            state_d      = S_WRITE;
          end else begin
            asm_d = {asm_q[15:0], byte_data};
            idx_d = idx_q + 2'd1;
          end
        end
      end

      S_WRITE: begin
        count_d = count_q + ONE_L;
        if ((count_q + ONE_L) == len_q) begin
          state_d = finish_state;
        end else begin
          state_d = S_DATA;
        end
      end

`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          state_d = (byte_data == csum_q) ? S_DONE : S_ERROR;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase

`ifdef LOADER_CHECKSUM_EN
    byte_ready_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CHK);
    busy_d       = (state_d == S_LEN) || (state_d == S_DATA) ||
                   (state_d == S_WRITE) || (state_d == S_CHK);
`else
    byte_ready_d = (state_d == S_LEN) || (state_d == S_DATA);
    busy_d       = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_WRITE);
`endif
    wr_en_d = (state_d == S_WRITE);
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERROR);
  end

  assign byte_ready = byte_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_address = wr_address_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed testbench for instruction_loader (default build; checksum cases
// are compiled in when LOADER_CHECKSUM_EN is defined).
module tb_instruction_loader;

  localparam int AW = 20;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          byte_ready;
  logic          wr_en;
  logic [AW-1:0] wr_address;
  logic [31:0]   wr_data;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW-1:0] word_count;

  instruction_loader #(
    .SIZE(110),
    .ADDR_WIDTH(AW),
    .BASE_ADDRESS(0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_ready(byte_ready),
    .wr_en(wr_en),
    .wr_address(wr_address),
    .wr_data(wr_data),
    .busy(busy),
    .done(done),
    .error(error),
    .word_count(word_count)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [AW-1:0] wa_log[$];
  logic [31:0]   wd_log[$];
  int            wc_log[$];
  logic          prev_wr = 1'b0;
  logic [7:0]    tx[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clock) cyc++;

  // Write monitor: log every strobe and flag back-to-back strobes.
  always @(negedge clock) begin
    if (wr_en) begin
      wa_log.push_back(wr_address);
      wd_log.push_back(wr_data);
      wc_log.push_back(cyc);
      $display("[TB] write addr=%0d data=%08h cycle=%0d", wr_address, wr_data, cyc);
      if (prev_wr) check("wr_en_back_to_back", 32'd1, 32'd0);
    end
    prev_wr = wr_en;
  end

  task automatic clear_log();
    wa_log.delete();
    wd_log.delete();
    wc_log.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic send_stream(input bit toggle);
    for (int i = 0; i < tx.size(); i++) begin
      bit ok;
      ok = 1'b0;
      byte_valid = 1'b1;
      byte_data  = tx[i];
      for (int n = 0; n < 40 && !ok; n++) begin
        @(negedge clock);
        if (byte_ready) begin
          @(posedge clock);
          #1 ok = 1'b1;
        end
      end
      if (!ok) begin
        check("byte_accept_timeout", 32'd0, 32'd1);
        byte_valid = 1'b0;
        return;
      end
      $display("[TB] byte %0d = %02h accepted", i, tx[i]);
      if (toggle) begin
        byte_valid = 1'b0;
        @(posedge clock);
        #1;
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 60 && !idle; n++) begin
      @(negedge clock);
      if (!busy) idle = 1'b1;
    end
    if (!idle) check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic load_main_stream();
    tx = '{8'h00, 8'h00, 8'h02, 8'h20, 8'h00, 8'h00, 8'h44, 8'h30, 8'h00, 8'h00, 8'h01};
`ifdef LOADER_CHECKSUM_EN
    tx.push_back(8'h57);
`endif
  endtask

  task automatic check_main_writes(input string pfx);
    check({pfx, "_nwrites"}, wa_log.size(), 32'd2);
    if (wa_log.size() >= 2) begin
      check({pfx, "_addr0"}, {12'd0, wa_log[0]}, 32'd0);
      check({pfx, "_data0"}, wd_log[0], 32'h20000044);
      check({pfx, "_addr1"}, {12'd0, wa_log[1]}, 32'd1);
      check({pfx, "_data1"}, wd_log[1], 32'h30000001);
    end
    check({pfx, "_done"}, {31'd0, done}, 32'd1);
    check({pfx, "_error"}, {31'd0, error}, 32'd0);
    check({pfx, "_busy"}, {31'd0, busy}, 32'd0);
    check({pfx, "_word_count"}, {12'd0, word_count}, 32'd2);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_wr_address", {12'd0, wr_address}, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_word_count", {12'd0, word_count}, 32'd0);

    // start in the cycle reset is released must be ignored
    @(posedge clock);
    #1 reset = 1'b0;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    check("start_at_reset_release_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of LEN
    pulse_start();
    tx = '{8'h00, 8'h00};
    send_stream(1'b0);
    #2 reset = 1'b1;
    @(negedge clock);
    check("midlen_rst_busy", {31'd0, busy}, 32'd0);
    check("midlen_rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("midlen_rst_done", {31'd0, done}, 32'd0);
    check("midlen_rst_error", {31'd0, error}, 32'd0);
    check("midlen_rst_wr_en", {31'd0, wr_en}, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // Two-word load, valid held high, with a spurious start mid-load
    clear_log();
    pulse_start();
    load_main_stream();
    fork
      send_stream(1'b0);
      begin
        repeat (6) @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
      end
    join
    wait_idle();
    check_main_writes("cont");
    if (wc_log.size() >= 2) check("cont_write_gap", wc_log[1] - wc_log[0], 32'd5);

    // Same stream, valid toggling every other cycle
    clear_log();
    pulse_start();
    load_main_stream();
    send_stream(1'b1);
    wait_idle();
    check_main_writes("toggle");

    // Oversize length 111
    clear_log();
    pulse_start();
    tx = '{8'h00, 8'h00, 8'h6F};
    send_stream(1'b0);
    wait_idle();
    check("over_error", {31'd0, error}, 32'd1);
    check("over_done", {31'd0, done}, 32'd0);
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    repeat (3) @(negedge clock);
    check("over_byte_ready", {31'd0, byte_ready}, 32'd0);
    byte_valid = 1'b0;
    check("over_nwrites", wa_log.size(), 32'd0);

    // Oversize through the upper length bits (0x100001)
    clear_log();
    pulse_start();
    tx = '{8'h10, 8'h00, 8'h01};
    send_stream(1'b0);
    wait_idle();
    check("upper_error", {31'd0, error}, 32'd1);
    check("upper_nwrites", wa_log.size(), 32'd0);

    // Zero-length load
    clear_log();
    pulse_start();
    tx = '{8'h00, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    tx.push_back(8'h00);
`endif
    send_stream(1'b0);
    wait_idle();
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_error", {31'd0, error}, 32'd0);
    check("zero_word_count", {12'd0, word_count}, 32'd0);
    check("zero_nwrites", wa_log.size(), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // Good checksum
    clear_log();
    pulse_start();
    tx = '{8'h00, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    send_stream(1'b0);
    wait_idle();
    check("csum_ok_done", {31'd0, done}, 32'd1);
    check("csum_ok_error", {31'd0, error}, 32'd0);
    check("csum_ok_nwrites", wa_log.size(), 32'd1);

    // Bad checksum: word is still written
    clear_log();
    pulse_start();
    tx = '{8'h00, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    send_stream(1'b0);
    wait_idle();
    check("csum_bad_error", {31'd0, error}, 32'd1);
    check("csum_bad_done", {31'd0, done}, 32'd0);
    check("csum_bad_nwrites", wa_log.size(), 32'd1);
    if (wa_log.size() >= 1) begin
      check("csum_bad_addr0", {12'd0, wa_log[0]}, 32'd0);
      check("csum_bad_data0", wd_log[0], 32'h11223344);
    end
`endif

    repeat (2) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
